stopwatch_core: RTL and testbench



---
 rtl/stopwatch_core.sv | 208 ++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//   MM:SS.hh BCD stopwatch clocked by clk100MHz. The 100 Hz divided clock
//   (clk_div) is treated as asynchronous: it is synchronised (s1 -> s2),
//   delayed once more (s3) and edge-detected into a one-cycle tick.
//   A small IDLE/RUN/PAUSE/SAT FSM decides whether a tick advances the count.
//
// Parameters
//   MAX_MIN : top minute value before overflow (1..99)
//   WRAP    : 0 = saturate at MAX_MIN:59.99 (SAT state, ovf held high)
//             1 = wrap to 00:00.00 with a one-cycle ovf pulse, stay in RUN
//
// Optional feature (macro STOPWATCH_LAP_EN)
//   Defined  : lap in RUN/PAUSE toggles a display freeze; while frozen the
//              digit outputs show a snapshot taken at the lap edge.
//   Undefined: lap is ignored and the digits always show the live count.
//
// Ports
//   clk100MHz       system clock
//   rst_n           asynchronous active-low reset
//   clk_div         100 Hz square wave, asynchronous to clk100MHz
//   start/stop/clear control pulses, priority clear > stop > start
//   lap             display freeze toggle (optional feature)
//   min_t..hs_u     BCD digits (minutes, seconds, hundredths; tens/units)
//   running         high while in RUN
//   ovf             overflow indicator (meaning depends on WRAP)
//   dbg_state       current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 SAT)
//
// Handshake: start/stop/clear/lap are level-sampled on every rising edge of
// clk100MHz; a one-cycle pulse is one request. There is no ready/ack.
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int MAX_MIN = 59,
    parameter int WRAP    = 0
) (
    input  logic       clk100MHz,
    input  logic       rst_n,
    input  logic       clk_div,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] hs_t,
    output logic [3:0] hs_u,
    output logic       running,
    output logic       ovf,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        SAT   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

    state_t      state, state_next;
    logic        s1, s2, s3, tick;
    logic [23:0] cnt, cnt_next, cnt_inc, disp;
    logic [3:0]  c_mt, c_mu, c_st, c_su, c_ht, c_hu;
    logic [3:0]  i_mt, i_mu, i_st, i_su, i_ht, i_hu;
    logic        at_max, count_en, wrap_evt;

    // Synchroniser plus one extra stage for rising-edge detection.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_div;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    assign {c_mt, c_mu, c_st, c_su, c_ht, c_hu} = cnt;

    assign at_max = (c_mt == MAX_T) && (c_mu == MAX_U) && (c_st == 4'd5) &&
                    (c_su == 4'd9) && (c_ht == 4'd9) && (c_hu == 4'd9);

    // A tick only counts in RUN when the FSM is not leaving RUN this cycle.
    assign count_en = (state == RUN) && tick && !clear && !stop;

    // BCD ripple increment; all carries resolve in one cycle.
    always_comb begin
        i_mt = c_mt;
        i_mu = c_mu;
        i_st = c_st;
        i_su = c_su;
        i_ht = c_ht;
        i_hu = c_hu;
        if (c_hu != 4'd9) begin
            i_hu = c_hu + 4'd1;
        end else begin
            i_hu = 4'd0;
            if (c_ht != 4'd9) begin
                i_ht = c_ht + 4'd1;
            end else begin
                i_ht = 4'd0;
                if (c_su != 4'd9) begin
                    i_su = c_su + 4'd1;
                end else begin
                    i_su = 4'd0;
                    if (c_st != 4'd5) begin
                        i_st = c_st + 4'd1;
                    end else begin
                        i_st = 4'd0;
                        if (c_mu != 4'd9) begin
                            i_mu = c_mu + 4'd1;
                        end else begin
                            i_mu = 4'd0;
                            i_mt = c_mt + 4'd1;
                        end
                    end
                end
            end
        end
        cnt_inc = {i_mt, i_mu, i_st, i_su, i_ht, i_hu};
    end

    // Next state and next count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wrap_evt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!clear && !stop && start) state_next = RUN;
            end
            RUN: begin
                if (clear)                                  state_next = IDLE;
                else if (stop)                              state_next = PAUSE;
                else if (tick && at_max && (WRAP == 0))     state_next = SAT;
            end
            PAUSE: begin
                if (clear)                  state_next = IDLE;
                else if (!stop && start)    state_next = RUN;
            end
            SAT: begin
                if (clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (clear) begin
            cnt_next = '0;
        end else if (count_en) begin
            if (!at_max) begin
                cnt_next = cnt_inc;
            end else if (WRAP != 0) begin
                cnt_next = '0;
                wrap_evt = 1'b1;
            end
            // at_max with WRAP == 0: hold, FSM moves to SAT
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            running <= (state_next == RUN);
            ovf     <= (state_next == SAT) | wrap_evt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        frozen;
    logic [23:0] snap;

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            frozen <= 1'b0;
            snap   <= '0;
        end else if (clear) begin
            frozen <= 1'b0;
        end else if (lap && ((state == RUN) || (state == PAUSE))) begin
            frozen <= ~frozen;
            snap   <= cnt;
        end
    end

    assign disp = frozen ? snap : cnt;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = cnt;
`endif

    assign {min_t, min_u, sec_t, sec_u, hs_t, hs_u} = disp;
    assign dbg_state = state;

endmodule

// File: tb/tb_stopwatch_core.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_core
//   Directed bench for stopwatch_core. Three instances share all stimulus:
//     u_a : MAX_MIN=59, WRAP=0 (default)
//     u_b : MAX_MIN=1,  WRAP=0 (saturation)
//     u_c : MAX_MIN=1,  WRAP=1 (wrap-around)
//   clk_div is driven as a fast square wave (one rise every 2 clocks) so the
//   minute boundaries are reachable in a short run.
// ---------------------------------------------------------------------------
module tb_stopwatch_core;

    // ---------------- clock / reset ----------------
    logic clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    logic rst_n, clk_div, start, stop, clear, lap;

    logic [3:0] a_mt, a_mu, a_st, a_su, a_ht, a_hu;
    logic [3:0] b_mt, b_mu, b_st, b_su, b_ht, b_hu;
    logic [3:0] c_mt, c_mu, c_st, c_su, c_ht, c_hu;
    logic       a_run, a_ovf, b_run, b_ovf, c_run, c_ovf;
    logic [1:0] a_dbg, b_dbg, c_dbg;
    logic [23:0] a_disp, b_disp, c_disp;

    assign a_disp = {a_mt, a_mu, a_st, a_su, a_ht, a_hu};
    assign b_disp = {b_mt, b_mu, b_st, b_su, b_ht, b_hu};
    assign c_disp = {c_mt, c_mu, c_st, c_su, c_ht, c_hu};

    stopwatch_core #(.MAX_MIN(59), .WRAP(0)) u_a (
        .clk100MHz(clk100MHz), .rst_n(rst_n), .clk_div(clk_div),
        .start(start), .stop(stop), .clear(clear), .lap(lap),
        .min_t(a_mt), .min_u(a_mu), .sec_t(a_st), .sec_u(a_su),
        .hs_t(a_ht), .hs_u(a_hu), .running(a_run), .ovf(a_ovf),
        .dbg_state(a_dbg)
    );

    stopwatch_core #(.MAX_MIN(1), .WRAP(0)) u_b (
        .clk100MHz(clk100MHz), .rst_n(rst_n), .clk_div(clk_div),
        .start(start), .stop(stop), .clear(clear), .lap(lap),
        .min_t(b_mt), .min_u(b_mu), .sec_t(b_st), .sec_u(b_su),
        .hs_t(b_ht), .hs_u(b_hu), .running(b_run), .ovf(b_ovf),
        .dbg_state(b_dbg)
    );

    stopwatch_core #(.MAX_MIN(1), .WRAP(1)) u_c (
        .clk100MHz(clk100MHz), .rst_n(rst_n), .clk_div(clk_div),
        .start(start), .stop(stop), .clear(clear), .lap(lap),
        .min_t(c_mt), .min_u(c_mu), .sec_t(c_st), .sec_u(c_su),
        .hs_t(c_ht), .hs_u(c_hu), .running(c_run), .ovf(c_ovf),
        .dbg_state(c_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, away from the active edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk100MHz);
            #1;
        end
    endtask

    // n clk_div rises, then enough idle edges for the last one to be counted.
    task automatic ticks(input int n);
        repeat (n) begin
            clk_div = 1'b1;
            step(1);
            clk_div = 1'b0;
            step(1);
        end
        step(3);
    endtask

    task automatic pulse(input logic s, input logic p, input logic c, input logic l);
        start = s;
        stop  = p;
        clear = c;
        lap   = l;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; clk_div = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(3);
        check("reset_digits", a_disp, 24'h000000);
        check("reset_status", {22'd0, a_run, a_ovf}, 24'd0);
        check("reset_state",  {22'd0, a_dbg}, 24'd0);
        rst_n = 1'b1;
        step(2);

        // start, then first-digit latency: 3 edges after the clk_div rise
        pulse(1, 0, 0, 0);
        check("start_running", {23'd0, a_run}, 24'd1);
        clk_div = 1'b1; step(1);
        clk_div = 1'b0; step(1);
        check("latency_2_edges", a_disp, 24'h000000);
        step(1);
        check("latency_3_edges", a_disp, 24'h000001);
        ticks(99);
        check("run_100_ticks", a_disp, 24'h000100);
        check("run_100_running", {23'd0, a_run}, 24'd1);

        pulse(0, 0, 1, 0);
        check("clear_digits", a_disp, 24'h000000);
        check("clear_running", {23'd0, a_run}, 24'd0);

        // start / stop / resume
        pulse(1, 0, 0, 0);
        ticks(250);
        pulse(0, 1, 0, 0);
        check("pause_250", a_disp, 24'h000250);
        check("pause_running", {23'd0, a_run}, 24'd0);
        ticks(50);
        check("pause_hold", a_disp, 24'h000250);
        pulse(1, 0, 0, 0);
        ticks(5);
        check("resume_255", a_disp, 24'h000255);

        // tick coinciding with stop is dropped
        clk_div = 1'b1; step(1);
        clk_div = 1'b0; step(1);
        stop = 1'b1; step(1); stop = 1'b0;
        check("stop_tick_dropped", a_disp, 24'h000255);
        check("stop_tick_state", {22'd0, a_dbg}, 24'd2);
        step(2);

        // tick coinciding with start is dropped
        clk_div = 1'b1; step(1);
        clk_div = 1'b0; step(1);
        start = 1'b1; step(1); start = 1'b0;
        check("start_tick_dropped", a_disp, 24'h000255);
        check("start_tick_running", {23'd0, a_run}, 24'd1);
        step(2);
        ticks(1);
        check("count_after_start", a_disp, 24'h000256);

        // full carry chain 00:59.99 -> 01:00.00
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        ticks(5999);
        check("reach_005999", a_disp, 24'h005999);
        ticks(1);
        check("carry_a_010000", a_disp, 24'h010000);
        check("carry_b_010000", b_disp, 24'h010000);

        // MAX_MIN=1 boundary
        ticks(5999);
        check("reach_b_015999", b_disp, 24'h015999);
        check("reach_c_015999", c_disp, 24'h015999);
        clk_div = 1'b1; step(1);
        clk_div = 1'b0; step(1);
        step(1);
        check("sat_digits", b_disp, 24'h015999);
        check("sat_status", {22'd0, b_run, b_ovf}, 24'd1);
        check("sat_state", {22'd0, b_dbg}, 24'd3);
        check("wrap_digits", c_disp, 24'h000000);
        check("wrap_status", {22'd0, c_run, c_ovf}, 24'd3);
        check("a_020000", a_disp, 24'h020000);
        step(1);
        check("wrap_ovf_pulse", {22'd0, c_run, c_ovf}, 24'd2);
        check("sat_ovf_held", {22'd0, b_run, b_ovf}, 24'd1);

        pulse(1, 0, 0, 0);
        ticks(3);
        check("sat_start_ignored", b_disp, 24'h015999);
        check("sat_start_status", {22'd0, b_run, b_ovf}, 24'd1);
        pulse(0, 1, 0, 0);
        check("sat_stop_ignored", {22'd0, b_dbg}, 24'd3);
        pulse(0, 0, 1, 0);
        check("sat_clear_digits", b_disp, 24'h000000);
        check("sat_clear_status", {22'd0, b_run, b_ovf}, 24'd0);

        // start + stop + clear together while running
        pulse(1, 0, 0, 0);
        ticks(7);
        check("pre_combo", c_disp, 24'h000007);
        pulse(1, 1, 1, 0);
        check("combo_digits", c_disp, 24'h000000);
        check("combo_status", {22'd0, c_run, c_ovf}, 24'd0);
        check("combo_state", {22'd0, c_dbg}, 24'd0);
        ticks(3);
        check("idle_no_count", c_disp, 24'h000000);

        // lap
        pulse(1, 0, 0, 0);
        ticks(320);
        check("pre_lap", a_disp, 24'h000320);
        pulse(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        ticks(100);
        check("lap_frozen", a_disp, 24'h000320);
        pulse(0, 0, 0, 1);
        check("lap_release", a_disp, 24'h000420);
`else
        check("lap_ignored_now", a_disp, 24'h000320);
        ticks(100);
        check("lap_ignored_live", a_disp, 24'h000420);
`endif

        // asynchronous reset mid-count
        clk_div = 1'b1; step(1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_digits", a_disp, 24'h000000);
        check("async_reset_status", {22'd0, a_run, a_ovf}, 24'd0);
        step(2);
        rst_n = 1'b1;
        clk_div = 1'b0;
        ticks(2);
        check("post_reset_idle", a_disp, 24'h000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
